// File: rtl/vec_mem_ctrl_pkg.sv
// Shared types and helpers for the vector memory controller: FSM states,
// address-map regions, the region decoder and the fixed ROM contents.
package vec_mem_ctrl_pkg;

  localparam int DEF_S     = 32;
  localparam int DEF_LANES = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;
  typedef enum logic [1:0] {RGN_ROM, RGN_RAM, RGN_REG, RGN_NONE} region_t;

  typedef struct packed {
    region_t     rgn;
    logic [31:0] off;
  } decode_t;

  // Regions are laid out back to back: ROM at base, then RAM, then REG.
  function automatic decode_t decode_addr(input logic [63:0] addr, input logic [63:0] base,
                                          input logic [63:0] n_rom, input logic [63:0] n_ram,
                                          input logic [63:0] n_reg);
    decode_t d;
    logic [63:0] ram_base, reg_base, reg_end;
    ram_base = base + n_rom;
    reg_base = ram_base + n_ram;
    reg_end  = reg_base + n_reg;
    d.rgn = RGN_NONE;
    d.off = '0;
    if (addr >= base && addr < ram_base) begin
      d.rgn = RGN_ROM;
      d.off = 32'(addr - base);
    end else if (addr >= ram_base && addr < reg_base) begin
      d.rgn = RGN_RAM;
      d.off = 32'(addr - ram_base);
    end else if (addr >= reg_base && addr < reg_end) begin
      d.rgn = RGN_REG;
      d.off = 32'(addr - reg_base);
    end
    return d;
  endfunction

  function automatic region_t region_of(input logic [63:0] addr, input logic [63:0] base,
                                        input logic [63:0] n_rom, input logic [63:0] n_ram,
                                        input logic [63:0] n_reg);
    decode_t d;
    d = decode_addr(addr, base, n_rom, n_ram, n_reg);
    return d.rgn;
  endfunction

  // ROM word k holds 0xC0DE0000 + k.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return 32'hC0DE_0000 + idx;
  endfunction

endpackage

// File: rtl/vec_mem_ram.sv
// Single-port data RAM with synchronous write and registered read.
module vec_mem_ram #(
  parameter int S        = 32,
  parameter int SIZE_RAM = 300,
  localparam int AW      = (SIZE_RAM > 1) ? $clog2(SIZE_RAM) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [S-1:0]  wd,
  output logic [S-1:0]  rd
);

  logic [S-1:0] mem [SIZE_RAM];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end

endmodule

// File: rtl/vec_mem_ctrl.sv
// Vector memory controller: one lane per cycle over a ROM/RAM/switch-register map.
// Define VEC_MEM_CTRL_ERR_EN to enable request legality checking and rsp_err.
module vec_mem_ctrl
  import vec_mem_ctrl_pkg::*;
#(
  parameter int S        = DEF_S,
  parameter int LANES    = DEF_LANES,
  parameter int SIZE_ROM = 300,
  parameter int SIZE_RAM = 300,
  parameter int SIZE_REG = 15,
  parameter int BASE     = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_vec,
  input  logic [S-1:0]          req_addr,
  input  logic [S*LANES-1:0]    req_wdata,
  input  logic [SIZE_REG*S-1:0] switch_regs,
  output logic                  rsp_valid,
  output logic [S*LANES-1:0]    rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int V      = S * LANES;
  localparam int SW1    = S + 1;
  localparam int CW     = $clog2(LANES + 1);
  localparam int RAM_AW = (SIZE_RAM > 1) ? $clog2(SIZE_RAM) : 1;
  localparam int REG_AW = (SIZE_REG > 1) ? $clog2(SIZE_REG) : 1;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, pend_lane_reg;
  logic            we_reg, vec_reg, err_reg, pend_reg;
  logic [S-1:0]    addr_reg;
  logic [V-1:0]    wdata_reg, hold_reg, merged;
  logic            accept, last_lane, illegal, ram_we;
  logic [S:0]      lane_addr;
  decode_t         lane_dec;
  logic [S-1:0]    lane_rdata, lane_wdata, ram_rd;
  logic [RAM_AW-1:0] ram_addr;
  logic [S-1:0]    sw_words [SIZE_REG];
  logic [S-1:0]    wd_words [LANES];

  assign accept    = req_valid && req_ready;
  assign last_lane = (cnt_reg == (vec_reg ? CW'(LANES - 1) : CW'(0)));

  for (genvar gi = 0; gi < SIZE_REG; gi++) begin : g_sw
    assign sw_words[gi] = switch_regs[gi*S +: S];
  end

`ifdef VEC_MEM_CTRL_ERR_EN
  // Regions are contiguous, so checking the first and last lane covers the span.
  logic [S:0] last_ext;
  region_t    first_rgn, last_rgn;
  always_comb begin
    last_ext  = {1'b0, req_addr} + (req_vec ? SW1'(LANES - 1) : SW1'(0));
    first_rgn = region_of(64'(req_addr), 64'(BASE), 64'(SIZE_ROM), 64'(SIZE_RAM), 64'(SIZE_REG));
    last_rgn  = region_of(64'(last_ext[S-1:0]), 64'(BASE), 64'(SIZE_ROM), 64'(SIZE_RAM),
                          64'(SIZE_REG));
    illegal   = last_ext[S] || (first_rgn == RGN_NONE) || (first_rgn != last_rgn) ||
                (req_we && (first_rgn != RGN_RAM));
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    lane_addr = {1'b0, addr_reg} + SW1'(cnt_reg);
    lane_dec  = decode_addr(64'(lane_addr[S-1:0]), 64'(BASE), 64'(SIZE_ROM), 64'(SIZE_RAM),
                            64'(SIZE_REG));
    if (lane_addr[S]) lane_dec.rgn = RGN_NONE;
    lane_rdata = '0;
    case (lane_dec.rgn)
      RGN_ROM: lane_rdata = S'(rom_word(lane_dec.off));
      RGN_REG: lane_rdata = sw_words[REG_AW'(lane_dec.off)];
      default: lane_rdata = '0;
    endcase
    ram_addr   = (lane_dec.rgn == RGN_RAM) ? RAM_AW'(lane_dec.off) : '0;
    lane_wdata = wd_words[cnt_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (req_valid) state_next = illegal ? ST_RESP : (req_we ? ST_WR : ST_RD);
      ST_RD, ST_WR: if (last_lane) state_next = ST_RESP;
      ST_RESP:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // The write enable is gated by rst so a lane in flight at reset is not written.
  always_comb begin
    req_ready = (state_reg == ST_IDLE);
    busy      = (state_reg != ST_IDLE);
    rsp_valid = (state_reg == ST_RESP);
    rsp_err   = rsp_valid && err_reg;
    ram_we    = (state_reg == ST_WR) && (lane_dec.rgn == RGN_RAM) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      vec_reg       <= 1'b0;
      err_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      pend_reg      <= 1'b0;
      pend_lane_reg <= '0;
      hold_reg      <= '0;
    end else begin
      pend_reg <= 1'b0;
      if (accept) begin
        cnt_reg   <= '0;
        we_reg    <= req_we;
        vec_reg   <= req_vec;
        err_reg   <= illegal;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (state_reg == ST_RD || state_reg == ST_WR) cnt_reg <= cnt_reg + CW'(1);
      // RAM data for this lane arrives one cycle later; remember where it goes.
      if (state_reg == ST_RD && lane_dec.rgn == RGN_RAM) begin
        pend_reg      <= 1'b1;
        pend_lane_reg <= cnt_reg;
      end
      if (state_reg == ST_RESP) hold_reg <= merged;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [S-1:0] lane_buf_reg;
    always_ff @(posedge clk) begin
      if (rst || accept) begin
        lane_buf_reg <= '0;
      end else if (pend_reg && pend_lane_reg == CW'(gi)) begin
        lane_buf_reg <= ram_rd;
      end else if (state_reg == ST_RD && !we_reg && cnt_reg == CW'(gi) &&
                   lane_dec.rgn != RGN_RAM) begin
        lane_buf_reg <= lane_rdata;
      end
    end
    assign merged[gi*S +: S] = (pend_reg && pend_lane_reg == CW'(gi)) ? ram_rd : lane_buf_reg;
    assign wd_words[gi]      = wdata_reg[gi*S +: S];
  end

  assign rsp_rdata = (state_reg == ST_RESP) ? merged : hold_reg;

  vec_mem_ram #(
    .S        (S),
    .SIZE_RAM (SIZE_RAM)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (lane_wdata),
    .rd   (ram_rd)
  );

endmodule

// File: tb/tb_vec_mem_ctrl.sv
// Scoreboard bench for vec_mem_ctrl: a memory-map reference model predicts each
// response at accept time; a monitor compares whenever rsp_valid is seen.
module tb_vec_mem_ctrl;
  import vec_mem_ctrl_pkg::*;

  localparam int S = 32, LANES = 6, V = S * LANES;
  localparam int SIZE_ROM = 300, SIZE_RAM = 300, SIZE_REG = 15, BASE = 500;
  localparam longint RAMB = BASE + SIZE_ROM;
  localparam longint REGB = RAMB + SIZE_RAM;
  localparam longint MEND = REGB + SIZE_REG;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_vec = 1'b0;
  logic [S-1:0] req_addr = '0;
  logic [V-1:0] req_wdata = '0;
  logic [SIZE_REG*S-1:0] switch_regs = '0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [V-1:0] rsp_rdata;

  vec_mem_ctrl #(.S(S), .LANES(LANES), .SIZE_ROM(SIZE_ROM), .SIZE_RAM(SIZE_RAM),
                 .SIZE_REG(SIZE_REG), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata), .switch_regs(switch_regs),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, passes = 0, n_rsp = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [V-1:0] rdata;
    logic         err;
    bit           rd;
    longint       acc;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] ram_m [SIZE_RAM];

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  function automatic logic [V-1:0] rand_vec();
    logic [V-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*S +: S] = $urandom;
    return v;
  endfunction

  function automatic region_t rgn_of(input longint a);
    if (a >= 64'h1_0000_0000 || a < BASE) return RGN_NONE;
    if (a < RAMB) return RGN_ROM;
    if (a < REGB) return RGN_RAM;
    if (a < MEND) return RGN_REG;
    return RGN_NONE;
  endfunction

  // Reference: whole request evaluated at once against the memory map.
  task automatic model(input logic we, input logic vec, input logic [31:0] addr,
                       input logic [V-1:0] wd, output exp_t e);
    int n;
    bit bad;
    region_t r0, r;
    longint a;
    n   = vec ? LANES : 1;
    bad = 0;
    r0  = rgn_of({32'b0, addr});
    for (int i = 0; i < n; i++) begin
      a = {32'b0, addr} + i;
      r = rgn_of(a);
      if (r == RGN_NONE || r != r0) bad = 1;
    end
    if (we && r0 != RGN_RAM) bad = 1;
`ifndef VEC_MEM_CTRL_ERR_EN
    bad = 0;
`endif
    e.rdata = '0;
    e.err   = bad;
    e.rd    = !we;
    e.acc   = cyc;
    e.lat   = bad ? 1 : n + 1;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        a = {32'b0, addr} + i;
        r = rgn_of(a);
        if (we) begin
          if (r == RGN_RAM) ram_m[int'(a - RAMB)] = wd[i*S +: S];
        end else begin
          case (r)
            RGN_ROM: e.rdata[i*S +: S] = 32'hC0DE_0000 + 32'(a - BASE);
            RGN_RAM: e.rdata[i*S +: S] = ram_m[int'(a - RAMB)];
            RGN_REG: e.rdata[i*S +: S] = switch_regs[int'(a - REGB)*S +: S];
            default: e.rdata[i*S +: S] = '0;
          endcase
        end
      end
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 60) begin
      t++;
      @(negedge clk);
    end
    if (!req_ready) chk("ready_timeout", req_ready, 1);
  endtask

  task automatic send(input logic we, input logic vec, input logic [31:0] addr,
                      input logic [V-1:0] wd, input bit new_sw);
    exp_t e;
    wait_ready();
    if (!req_ready) return;
    if (new_sw) for (int i = 0; i < SIZE_REG; i++) switch_regs[i*S +: S] = $urandom;
    req_we = we; req_vec = vec; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    model(we, vec, addr, wd, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    // Scramble the request fields: the controller must have captured them.
    req_valid = 1'b0; req_we = 1'($urandom); req_vec = 1'($urandom);
    req_addr = $urandom; req_wdata = rand_vec();
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_valid", rsp_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        n_rsp++;
        $display("rsp %0d: lat=%0d err=%0b rdata=%h", n_rsp, cyc - mon_e.acc, rsp_err, rsp_rdata);
        chk("latency", cyc - mon_e.acc, mon_e.lat);
        chk("rsp_err", rsp_err, mon_e.err);
        if (mon_e.rd) chk("rsp_rdata", rsp_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [V-1:0] wd;
    decode_t d;
    longint dec_a [8];
    longint acc_c[$];
    logic [31:0] a32;

    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;

    // Shared decoder at every region boundary.
    dec_a = '{BASE - 1, BASE, RAMB - 1, RAMB, REGB - 1, REGB, MEND - 1, MEND};
    for (int i = 0; i < 8; i++) begin
      d = decode_addr(64'(dec_a[i]), 64'(BASE), 64'(SIZE_ROM), 64'(SIZE_RAM), 64'(SIZE_REG));
      chk("decode_rgn", d.rgn, rgn_of(dec_a[i]));
      if (i inside {1, 3, 5}) chk("decode_off", d.off, 0);
      if (i inside {2, 4}) chk("decode_off", d.off, (i == 2) ? SIZE_ROM - 1 : SIZE_RAM - 1);
    end

    for (int i = 0; i < SIZE_REG; i++) switch_regs[i*S +: S] = $urandom;
    for (int k = 0; k < SIZE_RAM / LANES; k++) send(1, 1, 32'(RAMB + k * LANES), rand_vec(), 0);
    drain();

    wd = '0; wd[31:0] = 32'hDEAD_BEEF;
    send(1, 0, 32'(RAMB), wd, 0);
    send(0, 0, 32'(RAMB), rand_vec(), 0);
    drain();
    repeat (3) @(negedge clk);
    chk("rdata_hold", rsp_rdata, {160'b0, 32'hDEAD_BEEF});

    for (int i = 0; i < LANES; i++) wd[i*S +: S] = 32'h11 * i;
    send(1, 1, 32'(RAMB + 10), wd, 0);
    send(0, 1, 32'(RAMB + 10), rand_vec(), 0);
    send(0, 1, 32'(RAMB - 3), rand_vec(), 0);
    drain();

    switch_regs[3*S +: S] = 32'h0000_00A5;
    send(0, 0, 32'(REGB + 3), rand_vec(), 0);
    send(1, 0, 32'(REGB + 3), rand_vec(), 0);
    send(0, 0, 32'(REGB + 3), rand_vec(), 0);
    drain();

    // Reset lands on the third lane cycle of a vector write.
    wd = rand_vec();
    wait_ready();
    req_we = 1'b1; req_vec = 1'b1; req_addr = 32'(RAMB + 100); req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("abort_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    ram_m[100] = wd[31:0];
    ram_m[101] = wd[63:32];
    send(0, 1, 32'(RAMB + 100), rand_vec(), 0);
    drain();

    // req_valid held for 20 cycles of scalar reads.
    wait_ready();
    req_we = 1'b0; req_vec = 1'b0; req_addr = 32'(RAMB + $urandom_range(0, SIZE_RAM - 1));
    req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin
        exp_t e;
        model(1'b0, 1'b0, req_addr, req_wdata, e);
        exp_q.push_back(e);
        acc_c.push_back(cyc);
      end
      @(posedge clk);
      #1 req_addr = 32'(RAMB + $urandom_range(0, SIZE_RAM - 1));
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    chk("b2b_accepts", acc_c.size(), 7);
    for (int i = 1; i < acc_c.size(); i++) chk("b2b_spacing", acc_c[i] - acc_c[i-1], 3);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: a32 = 32'(BASE - 6 + $urandom_range(0, 10));
        1: a32 = 32'(RAMB - 6 + $urandom_range(0, 10));
        2: a32 = 32'(REGB - 6 + $urandom_range(0, 10));
        3: a32 = 32'(MEND - 6 + $urandom_range(0, 10));
        4: a32 = 32'hFFFF_FFFF - $urandom_range(0, 6);
        default: a32 = 32'(RAMB + $urandom_range(0, SIZE_RAM - 10));
      endcase
      send(1'($urandom), 1'($urandom), a32, rand_vec(), 1);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vec_mem_ctrl.md
VEC_MEM_CTRL -- requirements
Module: vec_mem_ctrl

Interface
REQ-001 Parameter S, default 32, lane (scalar word) width in bits.
REQ-002 Parameter LANES, default 6, lanes per vector access; V = S*LANES.
REQ-003 Parameter SIZE_ROM, default 300, data ROM depth in words.
REQ-004 Parameter SIZE_RAM, default 300, data RAM depth in words.
REQ-005 Parameter SIZE_REG, default 15, switch-register count.
REQ-006 Parameter BASE, default 500, word address of ROM word 0.
REQ-007 Address map: ROM at [BASE, BASE+SIZE_ROM), RAM immediately after, REG immediately after RAM.
REQ-008 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_vec  in  1  1 = LANES-word access, 0 = single word.
- req_addr  in  S  word address of lane 0.
- req_wdata  in  V  write data; lane i in bits [i*S +: S].
- switch_regs  in  SIZE_REG*S  live switch-register values; reg k in bits [k*S +: S].
- rsp_valid  out  1  one-cycle pulse, response complete.
- rsp_rdata  out  V  read data, lane-packed as req_wdata; scalar result in lane 0, other lanes 0.
- rsp_err  out  1  request rejected; valid with rsp_valid.
- busy  out  1  FSM not IDLE.

Function
REQ-009 FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-010 Handshake: request accepted on the edge where req_valid & req_ready; all request fields captured on that edge; later input changes are ignored.
REQ-011 IDLE -> RD (read) or WR (write) on acceptance, unless the request is illegal (REQ-016); an illegal request goes IDLE -> RESP.
REQ-012 RD/WR process one lane per cycle at address req_addr+i, i = 0..N-1, where N = LANES if req_vec else 1; after lane N-1, go to RESP.
REQ-013 RESP asserts rsp_valid for exactly one cycle, then returns to IDLE.
REQ-014 Latency from accept edge to rsp_valid high: N+1 cycles for legal requests, 1 cycle for illegal requests.
REQ-015 RAM is synchronous-read, synchronous-write.
- RAM write of lane i occurs on that lane's RD/WR cycle.
- ROM and REG reads are combinational, registered into the lane buffer.
REQ-016 A request is illegal if any of the following holds:
- any lane address falls outside the address map;
- the lane addresses span two regions;
- it is a write to ROM or REG.
REQ-017 An illegal request performs no RAM write and returns rsp_rdata = 0.
REQ-018 Address arithmetic uses S-bit unsigned values; req_addr+i overflowing 2^S counts as out of range.
REQ-019 Back-to-back requests: next request accepted no earlier than the cycle after rsp_valid.
REQ-020 A read of RAM address A in the cycle after a completed write to A returns the new data.
REQ-021 rsp_rdata holds its value until the next RESP.
REQ-022 REG reads sample switch_regs in the lane's cycle.

Reset
REQ-023 When rst is high at a clk edge:
- state = IDLE, lane counter = 0, req_ready = 1;
- rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, busy = 0.
REQ-024 Reset mid-burst aborts the burst and produces no rsp_valid; RAM lanes already written keep their values.
REQ-025 Reset does not clear RAM contents.

Configuration
REQ-026 Macro VEC_MEM_CTRL_ERR_EN defined: REQ-016/017 legality checking as specified, and rsp_err reports illegal requests.
REQ-027 Macro undefined:
- rsp_err is tied 0 and no legality check is performed;
- writes to ROM/REG are silently dropped;
- out-of-map lanes read 0;
- latency is always N+1.

Structure
REQ-028 Package vec_mem_ctrl_pkg holds the FSM state enum, region enum (ROM, RAM, REG, NONE), and the default S/LANES constants.
REQ-029 Sub-module vec_mem_ram: single-port synchronous RAM (parameters S, SIZE_RAM) with ports clk, we, addr, wd, rd.
REQ-030 Region decode (address -> region and offset) is a package function shared by the controller and the bench.

Verification
REQ-031 Scalar write 0xDEADBEEF to RAM word BASE+SIZE_ROM, then scalar read of the same word -> rsp_rdata lane0 = 0xDEADBEEF, rsp_err = 0, each response 2 cycles after accept.
REQ-032 Vector write of lanes {0,1,...,5}*0x11 to BASE+SIZE_ROM+10, then vector read -> identical V-bit data, rsp_valid 7 cycles after accept.
REQ-033 Vector read at BASE+SIZE_ROM-3 (spans ROM/RAM), with ERR_EN -> rsp_err = 1 and rdata = 0 one cycle after accept; without ERR_EN -> 7-cycle latency, lanes 0-2 from ROM, lanes 3-5 from RAM.
REQ-034 switch_regs reg3 = 0x0000_00A5 and scalar read at the REG base + 3 -> lane0 = 0xA5; scalar write to the same address with ERR_EN -> rsp_err = 1, reg unchanged.
REQ-035 rst asserted on the 3rd cycle of a vector write -> no rsp_valid, ready = 1 next cycle, lanes 0-1 written, lanes 2-5 unchanged.
REQ-036 req_valid held high for 20 cycles with scalar reads -> accepts spaced exactly 3 cycles apart, one rsp_valid per accept.
